// File: rtl/reg_scoreboard.sv
// Decode-side register hazard scoreboard.
// Tracks in-flight writes per architectural register with a small counter,
// stalls issue on RAW hazards (honouring the register file's same-cycle
// write bypass) and on destinations whose counter is saturated.
//
// Handshake: issueValid is raised by decode and must hold the instruction
// fields stable in that cycle; issueReady is combinational and, when high
// together with issueValid, means the instruction is accepted on this edge.
// issueReady is never high without issueValid.
module reg_scoreboard #(
    parameter int INDEX_BIT_WIDTH = 4,
    parameter int N_REGS          = (1 << INDEX_BIT_WIDTH),
    parameter int CNT_WIDTH       = 2,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issueValid,
    output logic                       issueReady,
    input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
    input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
    input  logic                       rdUse1,
    input  logic                       rdUse2,
    input  logic                       dstUse,
    input  logic [INDEX_BIT_WIDTH-1:0] dstIndex,
    input  logic                       wrtEn,
    input  logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
    input  logic                       flush,
    output logic [N_REGS-1:0]          busyMask,
    output logic [STALL_CNT_WIDTH-1:0] stallCount,
    output logic                       errUnderflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt [N_REGS];
    logic [N_REGS-1:0]    wbHit;
    logic                 srcHazard1;
    logic                 srcHazard2;
    logic                 dstHazard;
    logic                 accept;
    logic                 underflowEvent;

    // A commit only retires a write that is actually outstanding.
    always_comb begin
        wbHit = '0;
        for (int i = 0; i < N_REGS; i++) begin
            wbHit[i] = wrtEn && (wrtIndex == INDEX_BIT_WIDTH'(i)) && (cnt[i] != '0);
        end
    end

    // Hazard detection: a single pending write being committed this cycle is
    // readable through the register file bypass, so it is not a hazard.
    always_comb begin
        srcHazard1 = rdUse1 && ((cnt[rdIndex1] > CNT_ONE) ||
                                ((cnt[rdIndex1] == CNT_ONE) && !wbHit[rdIndex1]));
        srcHazard2 = rdUse2 && ((cnt[rdIndex2] > CNT_ONE) ||
                                ((cnt[rdIndex2] == CNT_ONE) && !wbHit[rdIndex2]));
        dstHazard  = dstUse && (cnt[dstIndex] == CNT_MAX) && !wbHit[dstIndex];
        issueReady = issueValid && !reset && !flush &&
                     !srcHazard1 && !srcHazard2 && !dstHazard;
        accept     = issueReady;
        underflowEvent = wrtEn && (cnt[wrtIndex] == '0);
    end

    // Busy view of the counters; cnt is registered so this is too.
    always_comb begin
        busyMask = '0;
        for (int i = 0; i < N_REGS; i++) begin
            busyMask[i] = (cnt[i] != '0);
        end
    end

    // In-flight counters: +1 on accepted issue, -1 on commit; flush drops all.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < N_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                cnt[i] <= cnt[i]
                        + CNT_WIDTH'(accept && dstUse && (dstIndex == INDEX_BIT_WIDTH'(i)))
                        - CNT_WIDTH'(wbHit[i]);
            end
        end
    end

    // Saturating count of cycles where decode waited; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (issueValid && !issueReady && (stallCount != '1)) begin
            stallCount <= stallCount + STALL_CNT_WIDTH'(1);
        end
    end

    // Sticky flag for a commit with nothing outstanding; commits are ignored
    // during a flush, so it cannot fire then.
    always_ff @(posedge clk) begin
        if (reset) begin
            errUnderflow <= 1'b0;
        end else if (!flush && underflowEvent) begin
            errUnderflow <= 1'b1;
        end
    end

endmodule
